// File: rtl/pkt_len_filter_if.sv
// Packet stream and configuration bus bundle for pkt_len_filter.
// The slave modport is the filter's view; master is the environment around it.
interface pkt_len_filter_if;
    logic         in_pkt_data_wr;
    logic [133:0] in_pkt_data;
    logic         in_pkt_valid_wr;
    logic         in_pkt_valid;
    logic         out_pkt_alf;

    logic         out_pkt_data_wr;
    logic [133:0] out_pkt_data;
    logic         out_pkt_valid_wr;
    logic         out_pkt_valid;
    logic         in_pkt_alf;

    logic         cfg_cs_n;
    logic         cfg_ack_n;
    logic         cfg_rw;
    logic [31:0]  cfg_addr;
    logic [31:0]  cfg_wdata;
    logic [31:0]  cfg_rdata;

    modport slave (
        input  in_pkt_data_wr, in_pkt_data, in_pkt_valid_wr, in_pkt_valid, in_pkt_alf,
        input  cfg_cs_n, cfg_rw, cfg_addr, cfg_wdata,
        output out_pkt_alf, out_pkt_data_wr, out_pkt_data, out_pkt_valid_wr, out_pkt_valid,
        output cfg_ack_n, cfg_rdata
    );

    modport master (
        output in_pkt_data_wr, in_pkt_data, in_pkt_valid_wr, in_pkt_valid, in_pkt_alf,
        output cfg_cs_n, cfg_rw, cfg_addr, cfg_wdata,
        input  out_pkt_alf, out_pkt_data_wr, out_pkt_data, out_pkt_valid_wr, out_pkt_valid,
        input  cfg_ack_n, cfg_rdata
    );
endinterface

// File: rtl/pkt_len_filter.sv
// Forwards packet words with one cycle of latency and marks each packet valid or
// dropped from its byte length against programmable min/max bounds.
module pkt_len_filter (
    input  logic              clk,
    input  logic              rst_n,
    pkt_len_filter_if.slave   bus
);

    typedef enum logic {
        IDLE,
        PKT
    } pkt_state_t;

    typedef enum logic [2:0] {
        IDLE_C,
        WRITE_C,
        READ_C,
        WAIT_C,
        ACK_C
    } cfg_state_t;

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b11;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    pkt_state_t   pkt_state, next_pkt_state;
    cfg_state_t   cfg_state;

    logic [15:0]  len, next_len;
    logic [1:0]   word_type;
    logic [15:0]  word_bytes;
    logic [16:0]  len_sum;
    logic [15:0]  len_sat;
    logic         accept;
    logic         tail_acc;
    logic         err_word;
    logic         err_vwr;
    logic [1:0]   err_inc;
    logic         in_range;
    logic         pkt_keep;

    logic         out_data_wr_q;
    logic [133:0] out_data_q;
    logic         out_valid_wr_q;
    logic         out_valid_q;

    logic         ctrl_en;
    logic [15:0]  min_len;
    logic [15:0]  max_len;
    logic [31:0]  pkt_in_cnt;
    logic [31:0]  drop_cnt;
    logic [31:0]  err_cnt;

    logic         cs_meta;
    logic         cs_s;
    logic         cfg_ack_n_q;
    logic [31:0]  cfg_rdata_q;
    logic [31:0]  reg_rdata;
    logic         cfg_wr;
    logic [7:0]   reg_addr;
    logic         unused_cfg_bits;

    assign bus.out_pkt_alf      = bus.in_pkt_alf;
    assign bus.out_pkt_data_wr  = out_data_wr_q;
    assign bus.out_pkt_data     = out_data_q;
    assign bus.out_pkt_valid_wr = out_valid_wr_q;
    assign bus.out_pkt_valid    = out_valid_q;
    assign bus.cfg_ack_n        = cfg_ack_n_q;
    assign bus.cfg_rdata        = cfg_rdata_q;

    assign reg_addr        = bus.cfg_addr[9:2];
    assign cfg_wr          = (cfg_state == WRITE_C);
    assign unused_cfg_bits = ^{bus.cfg_addr[31:10], bus.cfg_addr[1:0], bus.cfg_wdata[31:16]};

    // Length accumulates valid bytes per word and sticks at 16'hFFFF; the filter
    // decision uses the length including the tail word being accepted this cycle.
    always_comb begin
        word_type      = bus.in_pkt_data[133:132];
        word_bytes     = 16'd16 - {12'd0, bus.in_pkt_data[131:128]};
        len_sum        = {1'b0, len} + {1'b0, word_bytes};
        len_sat        = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        accept         = 1'b0;
        tail_acc       = 1'b0;
        err_word       = 1'b0;
        next_len       = len;
        next_pkt_state = pkt_state;
        if (bus.in_pkt_data_wr) begin
            if (pkt_state == IDLE) begin
                if (word_type == TYPE_HEAD) begin
                    accept         = 1'b1;
                    next_len       = word_bytes;
                    next_pkt_state = PKT;
                end else begin
                    err_word = 1'b1;
                end
            end else begin
                case (word_type)
                    TYPE_HEAD: begin
                        accept   = 1'b1;
                        err_word = 1'b1;
                        next_len = len_sat;
                    end
                    TYPE_BODY: begin
                        accept   = 1'b1;
                        next_len = len_sat;
                    end
                    TYPE_TAIL: begin
                        accept         = 1'b1;
                        tail_acc       = 1'b1;
                        next_len       = 16'd0;
                        next_pkt_state = IDLE;
                    end
                    default: err_word = 1'b1;
                endcase
            end
        end
        err_vwr  = bus.in_pkt_valid_wr & ~tail_acc;
        err_inc  = {1'b0, err_word} + {1'b0, err_vwr};
        in_range = (len_sat >= min_len) && (len_sat <= max_len);
        pkt_keep = bus.in_pkt_valid_wr & bus.in_pkt_valid & (~ctrl_en | in_range);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_state      <= IDLE;
            len            <= 16'd0;
            out_data_wr_q  <= 1'b0;
            out_data_q     <= '0;
            out_valid_wr_q <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            pkt_state      <= next_pkt_state;
            len            <= next_len;
            out_data_wr_q  <= accept;
            if (accept) begin
                out_data_q <= bus.in_pkt_data;
            end
            out_valid_wr_q <= tail_acc;
            out_valid_q    <= tail_acc & pkt_keep;
        end
    end

    // Config registers and counters; a host write to a counter clears it and
    // overrides any increment landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en    <= 1'b1;
            min_len    <= 16'd60;
            max_len    <= 16'd1518;
            pkt_in_cnt <= 32'd0;
            drop_cnt   <= 32'd0;
            err_cnt    <= 32'd0;
        end else begin
            if (cfg_wr && reg_addr == 8'd0) begin
                ctrl_en <= bus.cfg_wdata[0];
            end
            if (cfg_wr && reg_addr == 8'd1) begin
                min_len <= bus.cfg_wdata[15:0];
            end
            if (cfg_wr && reg_addr == 8'd2) begin
                max_len <= bus.cfg_wdata[15:0];
            end
            if (cfg_wr && reg_addr == 8'd3) begin
                pkt_in_cnt <= 32'd0;
            end else if (tail_acc) begin
                pkt_in_cnt <= pkt_in_cnt + 32'd1;
            end
            if (cfg_wr && reg_addr == 8'd4) begin
                drop_cnt <= 32'd0;
            end else if (tail_acc && !pkt_keep) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
            if (cfg_wr && reg_addr == 8'd5) begin
                err_cnt <= 32'd0;
            end else begin
                err_cnt <= err_cnt + {30'd0, err_inc};
            end
        end
    end

    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            8'd0:    reg_rdata = {31'd0, ctrl_en};
            8'd1:    reg_rdata = {16'd0, min_len};
            8'd2:    reg_rdata = {16'd0, max_len};
            8'd3:    reg_rdata = pkt_in_cnt;
            8'd4:    reg_rdata = drop_cnt;
            8'd5:    reg_rdata = err_cnt;
            default: reg_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta <= 1'b0;
            cs_s    <= 1'b0;
        end else begin
            cs_meta <= ~bus.cfg_cs_n;
            cs_s    <= cs_meta;
        end
    end

    // Host handshake: a new access only starts once the previous ack has been
    // withdrawn, so a held chip-select never triggers a second transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_state   <= IDLE_C;
            cfg_ack_n_q <= 1'b1;
            cfg_rdata_q <= 32'd0;
        end else begin
            case (cfg_state)
                IDLE_C: begin
                    cfg_ack_n_q <= 1'b1;
                    cfg_rdata_q <= 32'd0;
                    if (cs_s && cfg_ack_n_q) begin
                        cfg_state <= bus.cfg_rw ? READ_C : WRITE_C;
                    end
                end
                WRITE_C: cfg_state <= ACK_C;
                READ_C:  cfg_state <= WAIT_C;
                WAIT_C:  cfg_state <= ACK_C;
                ACK_C: begin
                    if (cs_s) begin
                        cfg_ack_n_q <= 1'b0;
                        cfg_rdata_q <= reg_rdata;
                    end else begin
                        cfg_ack_n_q <= 1'b1;
                        cfg_rdata_q <= 32'd0;
                        cfg_state   <= IDLE_C;
                    end
                end
                default: begin
                    cfg_state   <= IDLE_C;
                    cfg_ack_n_q <= 1'b1;
                    cfg_rdata_q <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_len_filter.sv
// Randomised bench for pkt_len_filter: a packet-level length model predicts the
// forwarded words, per-packet keep decisions and the three counters.
module tb_pkt_len_filter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pkt_len_filter_if bus();

    pkt_len_filter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    bit          m_en;
    int unsigned m_min, m_max, m_pkt_in, m_drop, m_err;

    logic [133:0] exp_words[$];
    logic         exp_valid[$];
    logic [133:0] exp_tail[$];
    logic [133:0] got_words[$];
    logic         got_valid[$];
    logic [133:0] got_tail[$];
    logic         got_tail_wr[$];
    int           stray_valid = 0;

    always begin
        @(posedge clk);
        #1;
        if (bus.out_pkt_data_wr === 1'b1) got_words.push_back(bus.out_pkt_data);
        if (bus.out_pkt_valid_wr === 1'b1) begin
            got_valid.push_back(bus.out_pkt_valid);
            got_tail.push_back(bus.out_pkt_data);
            got_tail_wr.push_back(bus.out_pkt_data_wr);
        end else if (rst_n === 1'b1 && bus.out_pkt_valid !== 1'b0) begin
            stray_valid++;
        end
    end

    function automatic logic [31:0] model_reg(input int addr);
        case (addr / 4)
            0:       return {31'd0, m_en};
            1:       return m_min;
            2:       return m_max;
            3:       return m_pkt_in;
            4:       return m_drop;
            5:       return m_err;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 1'b1; m_min = 60; m_max = 1518;
        m_pkt_in = 0; m_drop = 0; m_err = 0;
    endtask

    task automatic flush();
        exp_words.delete(); exp_valid.delete(); exp_tail.delete();
        got_words.delete(); got_valid.delete(); got_tail.delete(); got_tail_wr.delete();
    endtask

    task automatic drive_word(input logic [133:0] w, input logic vwr, input logic v);
        @(negedge clk);
        bus.in_pkt_data_wr  = 1'b1;
        bus.in_pkt_data     = w;
        bus.in_pkt_valid_wr = vwr;
        bus.in_pkt_valid    = v;
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_pkt_data_wr  = 1'b0;
            bus.in_pkt_valid_wr = 1'b0;
            bus.in_pkt_valid    = 1'b0;
        end
    endtask

    task automatic settle();
        drive_idle(1);
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata);
        int k;
        @(negedge clk);
        bus.in_pkt_data_wr  = 1'b0;
        bus.in_pkt_valid_wr = 1'b0;
        bus.cfg_cs_n  = 1'b0;
        bus.cfg_rw    = rw;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wdata;
        for (k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.cfg_ack_n === 1'b0) break;
        end
        rdata = bus.cfg_rdata;
        vectors++;
        if (k == 30) begin
            miscompares++;
            $display("[TB] FAIL cfg_ack_timeout: ack_n=%b after 30 cycles, expected 0", bus.cfg_ack_n);
        end
        @(negedge clk);
        bus.cfg_cs_n = 1'b1;
        for (k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.cfg_ack_n === 1'b1) break;
        end
        vectors++;
        if (k == 30) begin
            miscompares++;
            $display("[TB] FAIL cfg_release_timeout: ack_n=%b after 30 cycles, expected 1", bus.cfg_ack_n);
        end
        if (!rw) begin
            case (addr[9:2])
                8'd0: m_en = wdata[0];
                8'd1: m_min = wdata[15:0];
                8'd2: m_max = wdata[15:0];
                8'd3: m_pkt_in = 0;
                8'd4: m_drop = 0;
                8'd5: m_err = 0;
                default: ;
            endcase
        end
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        cfg_access(1'b0, addr, data, dummy);
    endtask

    task automatic cfg_read(input logic [31:0] addr, output logic [31:0] data);
        cfg_access(1'b1, addr, 32'd0, data);
    endtask

    // Reference: packet length is the plain sum of valid bytes, capped at 65535.
    task automatic send_packet(input int n, input logic [3:0] tail_inv, input logic vflag,
                               input bit rand_inv, input bit inject, input bit tail_vwr);
        logic [133:0] w;
        logic [1:0]   t;
        logic [3:0]   inv;
        logic         vwr;
        int           total = 0;
        int           plen;
        bit           keep;
        for (int i = 0; i < n; i++) begin
            t   = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
            inv = (i == n - 1) ? tail_inv : (rand_inv ? 4'($urandom_range(0, 15)) : 4'd0);
            vwr = (i == n - 1) ? tail_vwr : 1'b0;
            if (inject && i > 0 && i < n - 1) begin
                if ($urandom_range(0, 7) == 0) begin t = 2'b01; m_err++; end
                if ($urandom_range(0, 7) == 0) begin vwr = 1'b1; m_err++; end
            end
            w = {t, inv, $urandom, $urandom, $urandom, $urandom};
            total += 16 - int'(inv);
            exp_words.push_back(w);
            drive_word(w, vwr, vflag);
        end
        plen = (total > 65535) ? 65535 : total;
        keep = tail_vwr && vflag && (!m_en || (plen >= int'(m_min) && plen <= int'(m_max)));
        exp_valid.push_back(keep);
        exp_tail.push_back(w);
        m_pkt_in++;
        if (!keep) m_drop++;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        @(posedge clk); #1;
        vectors++;
        if (bus.out_pkt_data_wr !== 1'b0 || bus.out_pkt_valid_wr !== 1'b0 || bus.out_pkt_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes: got %b%b%b, expected 000",
                     bus.out_pkt_data_wr, bus.out_pkt_valid_wr, bus.out_pkt_valid);
        end
        vectors++;
        if (bus.out_pkt_data !== 134'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h, expected 0", bus.out_pkt_data);
        end
        vectors++;
        if (bus.cfg_ack_n !== 1'b1 || bus.cfg_rdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_cfg: ack_n=%b rdata=%h, expected 1 and 0", bus.cfg_ack_n, bus.cfg_rdata);
        end
        for (int a = 0; a < 2; a++) begin
            bus.in_pkt_alf = a[0];
            #1;
            vectors++;
            if (bus.out_pkt_alf !== a[0]) begin
                miscompares++;
                $display("[TB] FAIL alf_pass: got %b, expected %b", bus.out_pkt_alf, a[0]);
            end
        end
        bus.in_pkt_alf = 1'b0;
        for (int a = 0; a <= 28; a += 4) begin
            cfg_read(a, rd);
            vectors++;
            if (rd !== model_reg(a)) begin
                miscompares++;
                $display("[TB] FAIL reset_reg_%0h: got %0d, expected %0d", a, rd, model_reg(a));
            end
        end
    endtask

    task automatic test_basic_pkt();
        logic [133:0] w[4];
        logic [31:0]  rd;
        logic         exp_keep;
        exp_keep = !m_en || (64 >= m_min && 64 <= m_max);
        for (int i = 0; i < 4; i++)
            w[i] = {((i == 0) ? 2'b01 : ((i == 3) ? 2'b10 : 2'b11)), 4'd0, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            drive_word(w[i], i == 3, 1'b1);
            @(posedge clk); #1;
            vectors++;
            if (bus.out_pkt_data_wr !== 1'b1 || bus.out_pkt_data !== w[i]) begin
                miscompares++;
                $display("[TB] FAIL basic_fwd_%0d: wr=%b data=%h, expected 1 %h", i, bus.out_pkt_data_wr, bus.out_pkt_data, w[i]);
            end
            vectors++;
            if (bus.out_pkt_valid_wr !== (i == 3) || bus.out_pkt_valid !== ((i == 3) && exp_keep)) begin
                miscompares++;
                $display("[TB] FAIL basic_valid_%0d: got %b%b, expected %b%b", i, bus.out_pkt_valid_wr,
                         bus.out_pkt_valid, (i == 3), ((i == 3) && exp_keep));
            end
        end
        m_pkt_in++;
        drive_idle(1);
        @(posedge clk); #1;
        vectors++;
        if (bus.out_pkt_data_wr !== 1'b0 || bus.out_pkt_data !== w[3] || bus.out_pkt_valid_wr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_idle_hold: wr=%b vwr=%b data=%h, expected 0 0 %h",
                     bus.out_pkt_data_wr, bus.out_pkt_valid_wr, bus.out_pkt_data, w[3]);
        end
        cfg_read(32'hC, rd);
        vectors++;
        if (rd !== model_reg(32'hC)) begin
            miscompares++;
            $display("[TB] FAIL basic_pkt_in_cnt: got %0d, expected %0d", rd, model_reg(32'hC));
        end
        flush();
    endtask

    task automatic check_stream(input string name);
        // Stream comparisons are done inline in each test below.
    endtask

    task automatic test_short_pkt();
        logic [31:0] rd;
        int          n_bad;
        send_packet(3, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        send_packet(4, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        send_packet(4, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        cfg_read(32'h10, rd);
        vectors++;
        if (rd !== model_reg(32'h10)) begin
            miscompares++;
            $display("[TB] FAIL short_drop_cnt: got %0d, expected %0d", rd, model_reg(32'h10));
        end
        cfg_write(32'h0, 32'd0);
        send_packet(3, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        cfg_write(32'h0, 32'd1);
        n_bad = 0;
        for (int i = 0; i < exp_valid.size(); i++)
            if (i >= got_valid.size() || got_valid[i] !== exp_valid[i] || got_tail[i] !== exp_tail[i] || got_tail_wr[i] !== 1'b1)
                n_bad++;
        vectors++;
        if (n_bad != 0 || got_valid.size() != exp_valid.size()) begin
            miscompares++;
            $display("[TB] FAIL short_valid: got %0d flags (%0d wrong), expected %0d", got_valid.size(), n_bad, exp_valid.size());
        end
        vectors++;
        if (got_words != exp_words) begin
            miscompares++;
            $display("[TB] FAIL short_words: got %0d words, expected %0d matching", got_words.size(), exp_words.size());
        end
        flush();
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        drive_word({2'b11, 4'd0, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        m_err++;
        @(negedge clk);
        bus.in_pkt_data_wr  = 1'b0;
        bus.in_pkt_valid_wr = 1'b1;
        bus.in_pkt_valid    = 1'b1;
        m_err++;
        settle();
        vectors++;
        if (got_words.size() != 0 || got_valid.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL err_no_output: got %0d words %0d flags, expected 0 0", got_words.size(), got_valid.size());
        end
        cfg_read(32'h14, rd);
        vectors++;
        if (rd !== model_reg(32'h14)) begin
            miscompares++;
            $display("[TB] FAIL err_cnt_two: got %0d, expected %0d", rd, model_reg(32'h14));
        end
        cfg_write(32'h14, 32'd0);
        cfg_read(32'h14, rd);
        vectors++;
        if (rd !== model_reg(32'h14)) begin
            miscompares++;
            $display("[TB] FAIL err_cnt_clear: got %0d, expected %0d", rd, model_reg(32'h14));
        end
        // A lone tail in IDLE is a framing error, and its valid_wr is a second one.
        drive_word({2'b10, 4'd0, $urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
        m_err += 2;
        settle();
        cfg_read(32'h14, rd);
        vectors++;
        if (rd !== model_reg(32'h14) || got_words.size() != 0 || got_valid.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL err_tail_in_idle: cnt=%0d words=%0d, expected %0d and 0", rd, got_words.size(), model_reg(32'h14));
        end
        flush();
    endtask

    task automatic test_long_pkt();
        int n_bad;
        send_packet(100, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        cfg_write(32'h8, 32'd2000);
        send_packet(100, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        send_packet(125, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        send_packet(126, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        cfg_write(32'h4, 32'd65000);
        cfg_write(32'h8, 32'hFFFF);
        send_packet(4100, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        cfg_write(32'h4, 32'd60);
        cfg_write(32'h8, 32'd1518);
        n_bad = 0;
        for (int i = 0; i < exp_valid.size(); i++)
            if (i >= got_valid.size() || got_valid[i] !== exp_valid[i] || got_tail[i] !== exp_tail[i])
                n_bad++;
        vectors++;
        if (n_bad != 0 || got_valid.size() != exp_valid.size()) begin
            miscompares++;
            $display("[TB] FAIL long_valid: got %0d flags (%0d wrong), expected %0d", got_valid.size(), n_bad, exp_valid.size());
        end
        vectors++;
        if (got_words != exp_words) begin
            miscompares++;
            $display("[TB] FAIL long_words: got %0d words, expected %0d matching", got_words.size(), exp_words.size());
        end
        flush();
    endtask

    task automatic test_cfg_hold();
        int k;
        @(negedge clk);
        bus.cfg_cs_n = 1'b0;
        bus.cfg_rw   = 1'b1;
        bus.cfg_addr = 32'h4;
        for (k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.cfg_ack_n === 1'b0) break;
        end
        vectors++;
        if (k == 30) begin
            miscompares++;
            $display("[TB] FAIL hold_ack_timeout: ack_n=%b, expected 0", bus.cfg_ack_n);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.cfg_ack_n !== 1'b0 || bus.cfg_rdata !== model_reg(4)) begin
                miscompares++;
                $display("[TB] FAIL hold_read_%0d: ack_n=%b rdata=%0d, expected 0 %0d", c, bus.cfg_ack_n, bus.cfg_rdata, model_reg(4));
            end
        end
        @(negedge clk);
        bus.cfg_cs_n = 1'b1;
        for (k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (bus.cfg_ack_n === 1'b1) break;
        end
        vectors++;
        if (k > 3 || bus.cfg_rdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL hold_release: ack_n high after %0d cycles rdata=%0d, expected <=3 and 0", k, bus.cfg_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int          n_bad;
        drive_word({2'b01, 4'd0, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
        drive_word({2'b11, 4'd0, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        bus.in_pkt_data_wr = 1'b0;
        #1;
        vectors++;
        if (bus.out_pkt_data_wr !== 1'b0 || bus.out_pkt_data !== 134'd0 || bus.out_pkt_valid_wr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_outputs: wr=%b vwr=%b data=%h, expected 0 0 0",
                     bus.out_pkt_data_wr, bus.out_pkt_valid_wr, bus.out_pkt_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        flush();
        send_packet(4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        n_bad = 0;
        for (int i = 0; i < exp_valid.size(); i++)
            if (i >= got_valid.size() || got_valid[i] !== exp_valid[i] || got_tail[i] !== exp_tail[i])
                n_bad++;
        vectors++;
        if (n_bad != 0 || got_valid.size() != exp_valid.size() || got_words != exp_words) begin
            miscompares++;
            $display("[TB] FAIL mid_new_packet: got %0d words %0d flags, expected %0d %0d", got_words.size(),
                     got_valid.size(), exp_words.size(), exp_valid.size());
        end
        cfg_read(32'hC, rd);
        vectors++;
        if (rd !== model_reg(32'hC)) begin
            miscompares++;
            $display("[TB] FAIL mid_pkt_in_cnt: got %0d, expected %0d", rd, model_reg(32'hC));
        end
        flush();
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] rd;
        int          n_bad;
        for (int p = 0; p < 48; p++) begin
            if (p % 12 == 0) begin
                cfg_write(32'h4, $urandom_range(20, 80));
                cfg_write(32'h8, $urandom_range(40, 140));
                cfg_write(32'h0, $urandom_range(0, 3));
            end
            if ($urandom_range(0, 5) == 0) begin
                drive_word({2'b11, 4'd0, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
                m_err++;
            end
            send_packet($urandom_range(2, 9), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        1'b1, 1'b1, $urandom_range(0, 7) != 0);
        end
        settle();
        n_bad = 0;
        for (int i = 0; i < exp_valid.size(); i++)
            if (i >= got_valid.size() || got_valid[i] !== exp_valid[i] || got_tail[i] !== exp_tail[i] || got_tail_wr[i] !== 1'b1)
                n_bad++;
        vectors++;
        if (n_bad != 0 || got_valid.size() != exp_valid.size()) begin
            miscompares++;
            $display("[TB] FAIL rand_valid: got %0d flags (%0d wrong), expected %0d", got_valid.size(), n_bad, exp_valid.size());
        end
        n_bad = 0;
        for (int i = 0; i < exp_words.size(); i++)
            if (i >= got_words.size() || got_words[i] !== exp_words[i])
                n_bad++;
        vectors++;
        if (n_bad != 0 || got_words.size() != exp_words.size()) begin
            miscompares++;
            $display("[TB] FAIL rand_words: got %0d words (%0d wrong), expected %0d", got_words.size(), n_bad, exp_words.size());
        end
        for (int a = 12; a <= 20; a += 4) begin
            cfg_read(a, rd);
            vectors++;
            if (rd !== model_reg(a)) begin
                miscompares++;
                $display("[TB] FAIL rand_cnt_%0h: got %0d, expected %0d", a, rd, model_reg(a));
            end
        end
        vectors++;
        if (stray_valid != 0) begin
            miscompares++;
            $display("[TB] FAIL stray_valid: got %0d cycles, expected 0", stray_valid);
        end
        flush();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at 2 ms, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_pkt_data_wr  = 1'b0;
        bus.in_pkt_data     = '0;
        bus.in_pkt_valid_wr = 1'b0;
        bus.in_pkt_valid    = 1'b0;
        bus.in_pkt_alf      = 1'b0;
        bus.cfg_cs_n        = 1'b1;
        bus.cfg_rw          = 1'b0;
        bus.cfg_addr        = '0;
        bus.cfg_wdata       = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        test_reset();
        test_basic_pkt();
        test_short_pkt();
        test_errors();
        test_long_pkt();
        test_cfg_hold();
        test_reset_mid();
        test_random_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
